alu_issue_seq: RTL and testbench

// - Issue/sequencing stage that drives the MIPS ALU (a, b, 4-bit code) and consumes its result/zero flag.
// - Accepts one decoded instruction plus register operands per valid/ready handshake.
// - Maps opcode/funct to ALU codes and selects operands.
// - Runs one ALU pass, or two for BEQ.
// - Presents a writeback/branch result to the register file and PC logic.

---
 rtl/alu_issue_seq_if.sv | 33 +++
 rtl/alu_issue_seq.sv | 148 ++++++++++++++
 tb/tb_alu_issue_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_seq_if.sv
// alu_issue_seq_if: instruction handshake, ALU drive/return and writeback bundle.
interface alu_issue_seq_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [DATA_W-1:0]     in_rs_val;
  logic [DATA_W-1:0]     in_rt_val;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic [3:0]            alu_code;
  logic [DATA_W-1:0]     alu_result;
  logic                  alu_zero;
  logic                  out_valid;
  logic                  out_ready;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [DATA_W-1:0]     out_data;
  logic                  out_wen;
  logic                  out_br_taken;
  logic                  out_illegal;
  modport master (
    output in_valid, in_instr, in_rs_val, in_rt_val, alu_result, alu_zero, out_ready,
    input  in_ready, alu_a, alu_b, alu_code, out_valid, out_rd, out_data, out_wen,
           out_br_taken, out_illegal
  );
  modport slave (
    input  in_valid, in_instr, in_rs_val, in_rt_val, alu_result, alu_zero, out_ready,
    output in_ready, alu_a, alu_b, alu_code, out_valid, out_rd, out_data, out_wen,
           out_br_taken, out_illegal
  );
endinterface

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: decodes one MIPS instruction, sequences one or two ALU passes, holds the result.
module alu_issue_seq #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic           clk,
  input logic           rst_n,
  alu_issue_seq_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, EXEC1 = 2'd1, EXEC2 = 2'd2, DONE = 2'd3;
  logic [1:0]            state_q, state_d;
  logic [DATA_W-1:0]     a_q, a_d, b_q, b_d, data_q, data_d;
  logic [3:0]            code_q, code_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  wen_q, wen_d, br_q, br_d, ill_q, ill_d;
  logic                  valid_q, valid_d, beq_q, beq_d, z1_q, z1_d;
  logic [5:0]            op, fn;
  logic [DATA_W-1:0]     rs, rt, shamt, imm_s, imm_z, dec_a, dec_b;
  logic [3:0]            dec_code;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  dec_legal, dec_beq, unused;
  assign op     = bus.in_instr[31:26];
  assign fn     = bus.in_instr[5:0];
  assign rs     = bus.in_rs_val;
  assign rt     = bus.in_rt_val;
  assign shamt  = {{(DATA_W-5){1'b0}}, bus.in_instr[10:6]};
  assign imm_s  = {{(DATA_W-16){bus.in_instr[15]}}, bus.in_instr[15:0]};
  assign imm_z  = {{(DATA_W-16){1'b0}}, bus.in_instr[15:0]};
  assign unused = ^bus.in_instr[25:21];
  always_comb begin
    dec_code  = 4'b1111;
    dec_a     = rs;
    dec_b     = rt;
    dec_rd    = REG_ADDR_W'(bus.in_instr[20:16]);
    dec_legal = 1'b1;
    dec_beq   = 1'b0;
    if (op == 6'h00) begin
      dec_rd = REG_ADDR_W'(bus.in_instr[15:11]);
      case (fn)
        6'h24:   dec_code = 4'b0000;
        6'h25:   dec_code = 4'b0001;
        6'h20:   dec_code = 4'b0010;
        6'h22:   dec_code = 4'b0100;
        6'h2A:   begin dec_code = 4'b1000; dec_a = rt; dec_b = rs; end
        6'h00:   begin dec_code = 4'b0011; dec_a = rt; dec_b = shamt; end
        6'h02:   begin dec_code = 4'b1100; dec_a = rt; dec_b = shamt; end
        default: dec_legal = 1'b0;
      endcase
    end else begin
      case (op)
        6'h08:   begin dec_code = 4'b0010; dec_b = imm_s; end
        6'h0C:   begin dec_code = 4'b0000; dec_b = imm_z; end
        6'h0D:   begin dec_code = 4'b0001; dec_b = imm_z; end
        6'h04:   begin dec_code = 4'b1000; dec_beq = 1'b1; end
        default: dec_legal = 1'b0;
      endcase
    end
  end
  // BEQ compares a>b then b>a; equality is neither being greater
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    code_d  = code_q;
    data_d  = data_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    br_d    = br_q;
    ill_d   = ill_q;
    valid_d = valid_q;
    beq_d   = beq_q;
    z1_d    = z1_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        rd_d    = dec_rd;
        wen_d   = dec_legal & !dec_beq & (dec_rd != '0);
        ill_d   = !dec_legal;
        br_d    = 1'b0;
        data_d  = '0;
        beq_d   = dec_beq;
        a_d     = dec_legal ? dec_a : a_q;
        b_d     = dec_legal ? dec_b : b_q;
        code_d  = dec_legal ? dec_code : code_q;
        valid_d = !dec_legal;
        state_d = dec_legal ? EXEC1 : DONE;
      end
      EXEC1: if (beq_q) begin
        z1_d    = bus.alu_zero;
        a_d     = b_q;
        b_d     = a_q;
        state_d = EXEC2;
      end else begin
        data_d  = bus.alu_result;
        valid_d = 1'b1;
        state_d = DONE;
      end
      EXEC2: begin
        br_d    = z1_q & bus.alu_zero;
        valid_d = 1'b1;
        state_d = DONE;
      end
      default: if (bus.out_ready) begin
        valid_d = 1'b0;
        code_d  = 4'b1111;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      code_q  <= 4'b1111;
      data_q  <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      br_q    <= 1'b0;
      ill_q   <= 1'b0;
      valid_q <= 1'b0;
      beq_q   <= 1'b0;
      z1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      code_q  <= code_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      br_q    <= br_d;
      ill_q   <= ill_d;
      valid_q <= valid_d;
      beq_q   <= beq_d;
      z1_q    <= z1_d;
    end
  end
  assign bus.in_ready     = state_q == IDLE;
  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.alu_code     = code_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_data     = data_q;
  assign bus.out_wen      = wen_q;
  assign bus.out_br_taken = br_q;
  assign bus.out_illegal  = ill_q;
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: directed checks of decode, sequencing, backpressure and reset abort.
module tb_alu_issue_seq;
  logic clk, rst_n;
  int   n_cmp = 0, n_err = 0;
  alu_issue_seq_if #(.DATA_W(32), .REG_ADDR_W(5)) bif ();
  alu_issue_seq #(.DATA_W(32), .REG_ADDR_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0100: return a > b ? a - b : 32'd0;
      4'b1000: return {31'd0, a > b};
      4'b0011: return a << b[4:0];
      4'b1100: return a >> b[4:0];
      default: return 32'd0;
    endcase
  endfunction
  assign bif.alu_result = alu_f(bif.alu_code, bif.alu_a, bif.alu_b);
  assign bif.alu_zero   = bif.alu_result == 32'd0;
  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    bif.in_instr = ins; bif.in_rs_val = rs; bif.in_rt_val = rt; bif.in_valid = 1;
    @(posedge clk); #1;
    bif.in_valid = 0;
  endtask
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bif.out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
  endtask
  task automatic release_out;
    bif.out_ready = 1;
    @(posedge clk); #1;
    bif.out_ready = 0;
  endtask
  task automatic test_reset;
    rst_n = 0;
    bif.in_valid = 0; bif.in_instr = 0; bif.in_rs_val = 0; bif.in_rt_val = 0; bif.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bif.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", bif.out_valid); end
    n_cmp++; if (bif.alu_code !== 4'b1111) begin n_err++; $display("FAIL reset_code got %b want 1111", bif.alu_code); end
    n_cmp++; if ({bif.alu_a, bif.alu_b} !== 64'd0) begin n_err++; $display("FAIL reset_ab got %h %h want 0 0", bif.alu_a, bif.alu_b); end
    n_cmp++; if ({bif.out_wen, bif.out_br_taken, bif.out_illegal, bif.out_data} !== 35'd0) begin n_err++; $display("FAIL reset_outs got nonzero outputs"); end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    n_cmp++; if (bif.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", bif.in_ready); end
  endtask
  task automatic test_add;
    int lat;
    issue(rtype(1, 2, 3, 0, 6'h20), 32'd5, 32'd7);
    n_cmp++; if (bif.alu_code !== 4'b0010) begin n_err++; $display("FAIL add_code got %b want 0010", bif.alu_code); end
    n_cmp++; if ({bif.alu_a, bif.alu_b} !== {32'd5, 32'd7}) begin n_err++; $display("FAIL add_ab got %0d %0d want 5 7", bif.alu_a, bif.alu_b); end
    n_cmp++; if (bif.in_ready !== 1'b0) begin n_err++; $display("FAIL add_busy got %0b want 0", bif.in_ready); end
    wait_valid(lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL add_lat got %0d want 2", lat); end
    n_cmp++; if ({bif.out_rd, bif.out_data, bif.out_wen} !== {5'd3, 32'd12, 1'b1}) begin n_err++;
      $display("FAIL add_out got rd=%0d data=%0d wen=%0b want 3 12 1", bif.out_rd, bif.out_data, bif.out_wen); end
    release_out;
    n_cmp++; if ({bif.out_valid, bif.in_ready, bif.alu_code} !== {2'b01, 4'b1111}) begin n_err++;
      $display("FAIL add_release got valid=%0b ready=%0b code=%b want 0 1 1111", bif.out_valid, bif.in_ready, bif.alu_code); end
  endtask
  task automatic test_alu_ops;
    logic [31:0] ins [13], rsv [13], rtv [13], exp [13];
    logic [4:0]  erd [13];
    logic        ewen [13];
    int          lat;
    ins  = '{rtype(1,2,3,0,6'h24), rtype(1,2,3,0,6'h25), rtype(1,2,4,0,6'h22), rtype(1,2,4,0,6'h22),
             rtype(1,2,5,0,6'h2A), rtype(1,2,5,0,6'h2A), rtype(1,2,6,4,6'h00), rtype(1,2,6,3,6'h02),
             itype(6'h08,1,7,16'hFFFE), itype(6'h0C,1,8,16'h00FF), itype(6'h0D,1,9,16'h000F),
             itype(6'h08,1,0,16'hFFFF), rtype(1,2,31,0,6'h20)};
    rsv  = '{32'hF0F0, 32'h00F0, 32'd3, 32'd9, 32'd3, 32'd9, 32'hDEAD, 32'hDEAD, 32'd10, 32'hFFFF1234,
             32'hF0, 32'd1, 32'hFFFFFFFF};
    rtv  = '{32'hFF00, 32'h0F00, 32'd9, 32'd3, 32'd9, 32'd3, 32'd1, 32'h80, 32'd0, 32'd0, 32'd0, 32'd0, 32'd2};
    exp  = '{32'hF000, 32'h0FF0, 32'd0, 32'd6, 32'd1, 32'd0, 32'h10, 32'h10, 32'd8, 32'h34, 32'hFF, 32'd0, 32'd1};
    erd  = '{5'd3, 5'd3, 5'd4, 5'd4, 5'd5, 5'd5, 5'd6, 5'd6, 5'd7, 5'd8, 5'd9, 5'd0, 5'd31};
    ewen = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 13; i++) begin
      issue(ins[i], rsv[i], rtv[i]);
      if (i == 4) begin
        n_cmp++; if ({bif.alu_a, bif.alu_b} !== {32'd9, 32'd3}) begin n_err++; $display("FAIL sltu_swap got %0d %0d want 9 3", bif.alu_a, bif.alu_b); end
      end
      wait_valid(lat);
      n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL op%0d_lat got %0d want 2", i, lat); end
      n_cmp++; if ({bif.out_data, bif.out_rd, bif.out_wen, bif.out_illegal} !== {exp[i], erd[i], ewen[i], 1'b0}) begin n_err++;
        $display("FAIL op%0d_out got data=%h rd=%0d wen=%0b ill=%0b want %h %0d %0b 0", i, bif.out_data, bif.out_rd,
                 bif.out_wen, bif.out_illegal, exp[i], erd[i], ewen[i]); end
      release_out;
    end
  endtask
  task automatic test_beq;
    int lat;
    issue(itype(6'h04, 1, 2, 16'h0010), 32'h55, 32'h55);
    n_cmp++; if (bif.alu_code !== 4'b1000) begin n_err++; $display("FAIL beq_code got %b want 1000", bif.alu_code); end
    wait_valid(lat);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL beq_lat got %0d want 3", lat); end
    n_cmp++; if ({bif.out_br_taken, bif.out_wen, bif.out_illegal} !== 3'b100) begin n_err++;
      $display("FAIL beq_eq got br=%0b wen=%0b ill=%0b want 1 0 0", bif.out_br_taken, bif.out_wen, bif.out_illegal); end
    release_out;
    issue(itype(6'h04, 1, 2, 16'h0010), 32'd4, 32'd6);
    n_cmp++; if ({bif.alu_a, bif.alu_b} !== {32'd4, 32'd6}) begin n_err++; $display("FAIL beq_pass1 got %0d %0d want 4 6", bif.alu_a, bif.alu_b); end
    @(posedge clk); #1;
    n_cmp++; if ({bif.alu_a, bif.alu_b} !== {32'd6, 32'd4}) begin n_err++; $display("FAIL beq_pass2 got %0d %0d want 6 4", bif.alu_a, bif.alu_b); end
    wait_valid(lat);
    n_cmp++; if (bif.out_br_taken !== 1'b0) begin n_err++; $display("FAIL beq_lt got %0b want 0", bif.out_br_taken); end
    release_out;
    issue(itype(6'h04, 1, 2, 16'h0010), 32'd6, 32'd4);
    wait_valid(lat);
    n_cmp++; if (bif.out_br_taken !== 1'b0) begin n_err++; $display("FAIL beq_gt got %0b want 0", bif.out_br_taken); end
    release_out;
  endtask
  task automatic test_illegal;
    int lat;
    issue(32'hFC000000, 32'd1, 32'd2);
    wait_valid(lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL ill_lat got %0d want 1", lat); end
    n_cmp++; if ({bif.out_illegal, bif.out_wen, bif.alu_code} !== {2'b10, 4'b1111}) begin n_err++;
      $display("FAIL ill_op got ill=%0b wen=%0b code=%b want 1 0 1111", bif.out_illegal, bif.out_wen, bif.alu_code); end
    release_out;
    issue(rtype(1, 2, 3, 0, 6'h21), 32'd1, 32'd2);
    wait_valid(lat);
    n_cmp++; if ({bif.out_illegal, bif.out_wen, lat} !== {2'b10, 32'd1}) begin n_err++;
      $display("FAIL ill_fn got ill=%0b wen=%0b lat=%0d want 1 0 1", bif.out_illegal, bif.out_wen, lat); end
    release_out;
  endtask
  task automatic test_back_to_back;
    int lat;
    issue(rtype(1, 2, 10, 0, 6'h20), 32'd20, 32'd22);
    wait_valid(lat);
    bif.in_instr = rtype(1, 2, 11, 0, 6'h22); bif.in_rs_val = 32'd9; bif.in_rt_val = 32'd3; bif.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({bif.out_valid, bif.in_ready, bif.out_data, bif.out_rd} !== {2'b10, 32'd42, 5'd10}) begin n_err++;
        $display("FAIL hold%0d got valid=%0b ready=%0b data=%0d rd=%0d want 1 0 42 10", i, bif.out_valid, bif.in_ready, bif.out_data, bif.out_rd); end
    end
    release_out;
    n_cmp++; if ({bif.out_valid, bif.in_ready, bif.alu_code} !== {2'b01, 4'b1111}) begin n_err++;
      $display("FAIL hs_edge got valid=%0b ready=%0b code=%b want 0 1 1111", bif.out_valid, bif.in_ready, bif.alu_code); end
    @(posedge clk); #1;
    bif.in_valid = 0;
    n_cmp++; if ({bif.alu_code, bif.in_ready} !== {4'b0100, 1'b0}) begin n_err++;
      $display("FAIL resume got code=%b ready=%0b want 0100 0", bif.alu_code, bif.in_ready); end
    wait_valid(lat);
    n_cmp++; if ({bif.out_data, bif.out_rd, lat} !== {32'd6, 5'd11, 32'd2}) begin n_err++;
      $display("FAIL resume_out got data=%0d rd=%0d lat=%0d want 6 11 2", bif.out_data, bif.out_rd, lat); end
    release_out;
  endtask
  task automatic test_reset_abort;
    int lat;
    logic seen;
    issue(rtype(1, 2, 3, 0, 6'h20), 32'd5, 32'd7);
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({bif.out_valid, bif.alu_code} !== {1'b0, 4'b1111}) begin n_err++;
      $display("FAIL abort_exec got valid=%0b code=%b want 0 1111", bif.out_valid, bif.alu_code); end
    @(negedge clk) rst_n = 1;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; seen |= bif.out_valid; end
    n_cmp++; if ({seen, bif.in_ready} !== 2'b01) begin n_err++; $display("FAIL abort_idle got seen=%0b ready=%0b want 0 1", seen, bif.in_ready); end
    issue(rtype(1, 2, 3, 0, 6'h20), 32'd1, 32'd1);
    wait_valid(lat);
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({bif.out_valid, bif.out_data} !== {1'b0, 32'd0}) begin n_err++;
      $display("FAIL abort_done got valid=%0b data=%0d want 0 0", bif.out_valid, bif.out_data); end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    n_cmp++; if (bif.in_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got %0b want 1", bif.in_ready); end
  endtask
  initial begin
    test_reset;
    test_add;
    test_alu_ops;
    test_beq;
    test_illegal;
    test_back_to_back;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
